// File: rtl/buzzer_tone_gen_if.sv
// Signal bundle between the note sequencer and the buzzer tone generator.
// There is no valid/ready handshake: the sequencer holds note_in, octave_in
// and mute as levels, and the generator samples them on every clock.
// The four outputs are registered status and pin levels, valid every cycle.
interface buzzer_tone_gen_if;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       mute;
    logic       speaker_out;
    logic       tone_active;
    logic [3:0] cur_note;
    logic [1:0] cur_octave;

    modport master (
        output note_in, octave_in, mute,
        input  speaker_out, tone_active, cur_note, cur_octave
    );

    modport slave (
        input  note_in, octave_in, mute,
        output speaker_out, tone_active, cur_note, cur_octave
    );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Piezo buzzer square-wave generator with IDLE/TONE/GAP sequencing.
// Inputs are registered once, and the FSM acts only on the registered copy.
// A change between two different keys inserts a silent articulation gap.
// All outputs are registered, so no input-to-output combinational path exists.
module buzzer_tone_gen #(
    parameter int GAP_CYCLES = 1000000,
    parameter int DIV_SHIFT  = 0
) (
    input  logic               clk,
    input  logic               reset,
    buzzer_tone_gen_if.slave   bus,
    output logic [1:0]         fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The gap counter only has to reach GAP_CYCLES-1.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  req_note;
    logic [1:0]  req_oct;
    logic        req_mute;
    logic [19:0] phase, phase_n;
    logic [19:0] half_reg, half_n;
    logic [GAP_W-1:0] gap, gap_n;
    logic        spk, spk_n;
    logic        act, act_n;
    logic [3:0]  note_r, note_n;
    logic [1:0]  oct_r, oct_n;

    logic        tgt_silent;
    logic [1:0]  tgt_oct;
    logic [19:0] tgt_half;
    logic        tgt_differs;

    // Half period in clocks for a note and an effective octave, after the
    // simulation divide. A result of zero is clamped to one clock.
    function automatic logic [19:0] half_lookup(input logic [3:0] note,
                                                input logic [1:0] oct);
        logic [19:0] base;
        logic [19:0] scaled;
        case (note)
            4'd1:    base = 20'd191113;
            4'd2:    base = 20'd170262;
            4'd3:    base = 20'd151686;
            4'd4:    base = 20'd143173;
            4'd5:    base = 20'd127551;
            4'd6:    base = 20'd113636;
            4'd7:    base = 20'd101238;
            default: base = 20'd0;
        endcase
        case (oct)
            2'b01:   scaled = base << 1;
            2'b10:   scaled = base >> 1;
            default: scaled = base;
        endcase
        scaled = scaled >> DIV_SHIFT;
        if (scaled == 20'd0) begin
            scaled = 20'd1;
        end
        return scaled;
    endfunction

    // Target decode from the registered request; mute wins over any note.
    always_comb begin
        tgt_silent  = req_mute || (req_note == 4'd0) || (req_note > 4'd7);
        tgt_oct     = (req_oct == 2'b11) ? 2'b00 : req_oct;
        tgt_half    = half_lookup(req_note, tgt_oct);
        tgt_differs = (req_note != note_r) || (tgt_oct != oct_r);
    end

    // Input stage: sample the sequencer levels every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_note <= 4'd0;
            req_oct  <= 2'd0;
            req_mute <= 1'b0;
        end else begin
            req_note <= bus.note_in;
            req_oct  <= bus.octave_in;
            req_mute <= bus.mute;
        end
    end

    // State, counters and registered outputs; reset aborts any tone or gap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            phase    <= 20'd0;
            half_reg <= 20'd1;
            gap      <= '0;
            spk      <= 1'b0;
            act      <= 1'b0;
            note_r   <= 4'd0;
            oct_r    <= 2'd0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            half_reg <= half_n;
            gap      <= gap_n;
            spk      <= spk_n;
            act      <= act_n;
            note_r   <= note_n;
            oct_r    <= oct_n;
        end
    end

    // Next-state and next-output logic for IDLE/TONE/GAP.
    always_comb begin
        state_n = state;
        phase_n = phase;
        half_n  = half_reg;
        gap_n   = gap;
        spk_n   = spk;
        act_n   = act;
        note_n  = note_r;
        oct_n   = oct_r;
        case (state)
            IDLE: begin
                spk_n  = 1'b0;
                act_n  = 1'b0;
                note_n = 4'd0;
                oct_n  = 2'd0;
                if (!tgt_silent) begin
                    state_n = TONE;
                    half_n  = tgt_half;
                    phase_n = 20'd0;
                    spk_n   = 1'b1;
                    act_n   = 1'b1;
                    note_n  = req_note;
                    oct_n   = tgt_oct;
                end
            end
            TONE: begin
                if (tgt_silent) begin
                    state_n = IDLE;
                    phase_n = 20'd0;
                    spk_n   = 1'b0;
                    act_n   = 1'b0;
                    note_n  = 4'd0;
                    oct_n   = 2'd0;
                end else if (tgt_differs) begin
                    state_n = GAP;
                    phase_n = 20'd0;
                    gap_n   = '0;
                    spk_n   = 1'b0;
                    act_n   = 1'b0;
                    note_n  = 4'd0;
                    oct_n   = 2'd0;
                end else if (phase == half_reg - 20'd1) begin
                    // Same key keeps running; toggle at the end of each half.
                    spk_n   = ~spk;
                    phase_n = 20'd0;
                end else begin
                    phase_n = phase + 20'd1;
                end
            end
            GAP: begin
                spk_n = 1'b0;
                act_n = 1'b0;
                if (gap == GAP_LAST) begin
                    // Only the target at the end of the gap matters.
                    if (tgt_silent) begin
                        state_n = IDLE;
                    end else begin
                        state_n = TONE;
                        half_n  = tgt_half;
                        phase_n = 20'd0;
                        spk_n   = 1'b1;
                        act_n   = 1'b1;
                        note_n  = req_note;
                        oct_n   = tgt_oct;
                    end
                end else begin
                    gap_n = gap + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                spk_n   = 1'b0;
                act_n   = 1'b0;
                note_n  = 4'd0;
                oct_n   = 2'd0;
            end
        endcase
    end

    // Drive the registered values onto the bundle and the debug state.
    always_comb begin
        bus.speaker_out = spk;
        bus.tone_active = act;
        bus.cur_note    = note_r;
        bus.cur_octave  = oct_r;
        fsm_state       = state;
    end
endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen with DIV_SHIFT=10, GAP_CYCLES=8.
// Inputs change on the falling edge, so they are sampled at the following
// rising edge; outputs are sampled on falling edges as well.
module tb_buzzer_tone_gen;
    localparam int GAP_CYCLES = 8;
    localparam int DIV_SHIFT  = 10;
    localparam int LIMIT      = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] fsm_state;
    int         vectors = 0;
    int         miscompares = 0;

    buzzer_tone_gen_if bus();

    buzzer_tone_gen #(.GAP_CYCLES(GAP_CYCLES), .DIV_SHIFT(DIV_SHIFT)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Reference: table value scaled by octave, divided by 2^DIV_SHIFT, min 1.
    function automatic int model_half(input int note, input int oct);
        int v;
        int eff;
        case (note)
            1: v = 191113;
            2: v = 170262;
            3: v = 151686;
            4: v = 143173;
            5: v = 127551;
            6: v = 113636;
            7: v = 101238;
            default: v = 0;
        endcase
        eff = (oct == 3) ? 0 : oct;
        if (eff == 1) v = v * 2;
        else if (eff == 2) v = v / 2;
        v = v / (1 << DIV_SHIFT);
        if (v < 1) v = 1;
        return v;
    endfunction

    function automatic int model_oct(input int oct);
        return (oct == 3) ? 0 : oct;
    endfunction

    task automatic apply(input int note, input int oct, input bit m);
        bus.note_in   = 4'(note);
        bus.octave_in = 2'(oct);
        bus.mute      = m;
    endtask

    // Falling edges until speaker_out equals level (bounded).
    task automatic wait_level(input logic level, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.speaker_out !== level && n < LIMIT);
    endtask

    // Length of the run at level that starts at the current sample.
    task automatic run_length(input logic level, output int len);
        len = 1;
        @(negedge clk);
        while (bus.speaker_out === level && len < LIMIT) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic go_silent();
        apply(0, 0, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        apply(0, 0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.speaker_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_speaker got %b want 0", bus.speaker_out);
        end
        vectors++;
        if (bus.tone_active !== 1'b0) begin
            miscompares++; $display("FAIL reset_active got %b want 0", bus.tone_active);
        end
        vectors++;
        if (bus.cur_note !== 4'd0 || bus.cur_octave !== 2'd0) begin
            miscompares++; $display("FAIL reset_cur got %0d/%0d want 0/0", bus.cur_note, bus.cur_octave);
        end
        vectors++;
        if (fsm_state !== 2'd0) begin
            miscompares++; $display("FAIL reset_state got %0d want 0", fsm_state);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_a_mid();
        int n;
        int len;
        apply(6, 0, 1'b0);
        wait_level(1'b1, n);
        vectors++;
        if (n !== 2) begin
            miscompares++; $display("FAIL a_latency got %0d want 2", n);
        end
        vectors++;
        if (bus.tone_active !== 1'b1 || bus.cur_note !== 4'd6 || bus.cur_octave !== 2'd0) begin
            miscompares++; $display("FAIL a_status got %b/%0d/%0d want 1/6/0", bus.tone_active, bus.cur_note, bus.cur_octave);
        end
        for (int k = 0; k < 3; k++) begin
            run_length(k[0] ? 1'b0 : 1'b1, len);
            vectors++;
            if (len !== 110) begin
                miscompares++; $display("FAIL a_half%0d got %0d want 110", k, len);
            end
        end
        go_silent();
    endtask

    task automatic test_octaves();
        int notes [2] = '{1, 7};
        int octs  [2] = '{1, 2};
        int halves[2] = '{373, 49};
        int n;
        int len;
        for (int k = 0; k < 2; k++) begin
            apply(notes[k], octs[k], 1'b0);
            wait_level(1'b1, n);
            vectors++;
            if (bus.cur_octave !== 2'(octs[k])) begin
                miscompares++; $display("FAIL oct_cur got %0d want %0d", bus.cur_octave, octs[k]);
            end
            run_length(1'b1, len);
            vectors++;
            if (len !== halves[k]) begin
                miscompares++; $display("FAIL oct_high%0d got %0d want %0d", k, len, halves[k]);
            end
            run_length(1'b0, len);
            vectors++;
            if (len !== halves[k]) begin
                miscompares++; $display("FAIL oct_low%0d got %0d want %0d", k, len, halves[k]);
            end
            go_silent();
        end
    endtask

    task automatic test_random_notes();
        int note;
        int oct;
        int n;
        int len;
        int exp_h;
        for (int k = 0; k < 8; k++) begin
            note  = $urandom_range(1, 7);
            oct   = $urandom_range(0, 3);
            exp_h = model_half(note, oct);
            apply(note, oct, 1'b0);
            wait_level(1'b1, n);
            vectors++;
            if (n !== 2 || bus.cur_note !== 4'(note) || bus.cur_octave !== 2'(model_oct(oct))) begin
                miscompares++;
                $display("FAIL rnd_start lat %0d note %0d oct %0d want 2/%0d/%0d", n, bus.cur_note, bus.cur_octave, note, model_oct(oct));
            end
            run_length(1'b1, len);
            vectors++;
            if (len !== exp_h) begin
                miscompares++; $display("FAIL rnd_high got %0d want %0d", len, exp_h);
            end
            run_length(1'b0, len);
            vectors++;
            if (len !== exp_h) begin
                miscompares++; $display("FAIL rnd_low got %0d want %0d", len, exp_h);
            end
            go_silent();
        end
    endtask

    // Switch from key a to key b during a high half; optionally retarget
    // to key c part-way through the gap.
    task automatic run_gap(input int na, input int oa, input int nb, input int ob,
                           input bit retarget, input int nc, input int oc);
        int n;
        int first_low;
        int rise;
        int len;
        int fin_n;
        int fin_o;
        logic act_in_gap;
        logic [3:0] note_in_gap;
        fin_n = retarget ? nc : nb;
        fin_o = retarget ? oc : ob;
        apply(na, oa, 1'b0);
        wait_level(1'b1, n);
        apply(nb, ob, 1'b0);
        first_low   = 0;
        rise        = 0;
        act_in_gap  = 1'b1;
        note_in_gap = 4'hf;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (retarget && i == 4) apply(nc, oc, 1'b0);
            if (first_low == 0 && bus.speaker_out === 1'b0) begin
                first_low   = i;
                act_in_gap  = bus.tone_active;
                note_in_gap = bus.cur_note;
            end else if (first_low != 0 && bus.speaker_out === 1'b1) begin
                rise = i;
                break;
            end
        end
        vectors++;
        if (first_low !== 2 || act_in_gap !== 1'b0 || note_in_gap !== 4'd0) begin
            miscompares++;
            $display("FAIL gap_enter at %0d act %b note %0d want 2/0/0", first_low, act_in_gap, note_in_gap);
        end
        vectors++;
        if (rise - first_low !== GAP_CYCLES) begin
            miscompares++; $display("FAIL gap_length got %0d want %0d", rise - first_low, GAP_CYCLES);
        end
        vectors++;
        if (bus.tone_active !== 1'b1 || bus.cur_note !== 4'(fin_n) || bus.cur_octave !== 2'(model_oct(fin_o))) begin
            miscompares++;
            $display("FAIL gap_next got %b/%0d/%0d want 1/%0d/%0d", bus.tone_active, bus.cur_note, bus.cur_octave, fin_n, model_oct(fin_o));
        end
        run_length(1'b1, len);
        vectors++;
        if (len !== model_half(fin_n, fin_o)) begin
            miscompares++; $display("FAIL gap_half got %0d want %0d", len, model_half(fin_n, fin_o));
        end
        go_silent();
    endtask

    task automatic test_gap();
        int na;
        int oa;
        int nb;
        int ob;
        run_gap(6, 0, 5, 0, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            na = $urandom_range(1, 7);
            oa = $urandom_range(0, 3);
            do begin
                nb = $urandom_range(1, 7);
                ob = $urandom_range(0, 3);
            end while (nb == na && model_oct(ob) == model_oct(oa));
            run_gap(na, oa, nb, ob, 1'b0, 0, 0);
        end
    endtask

    task automatic test_gap_change();
        run_gap(3, 0, 4, 0, 1'b1, 2, 0);
    endtask

    // Octave 11 is the same key as 00, so the wave must not be disturbed.
    task automatic test_same_key();
        int n;
        int len;
        apply(4, 0, 1'b0);
        wait_level(1'b1, n);
        apply(4, 3, 1'b0);
        run_length(1'b1, len);
        vectors++;
        if (len !== model_half(4, 0) || bus.tone_active !== 1'b1 || bus.cur_octave !== 2'd0) begin
            miscompares++;
            $display("FAIL same_key high %0d act %b oct %0d want %0d/1/0", len, bus.tone_active, bus.cur_octave, model_half(4, 0));
        end
        go_silent();
    endtask

    task automatic test_mute();
        int n;
        for (int k = 0; k < 3; k++) begin
            apply(2, 0, 1'b0);
            wait_level(1'b1, n);
            case (k)
                0: apply(2, 0, 1'b1);
                1: apply(0, 0, 1'b0);
                default: apply(15, 0, 1'b0);
            endcase
            @(negedge clk);
            vectors++;
            if (bus.tone_active !== 1'b1) begin
                miscompares++; $display("FAIL mute_early%0d got %b want 1", k, bus.tone_active);
            end
            @(negedge clk);
            vectors++;
            if (bus.speaker_out !== 1'b0 || bus.tone_active !== 1'b0 || bus.cur_note !== 4'd0) begin
                miscompares++;
                $display("FAIL mute_idle%0d got %b/%b/%0d want 0/0/0", k, bus.speaker_out, bus.tone_active, bus.cur_note);
            end
            apply(2, 0, 1'b0);
            wait_level(1'b1, n);
            vectors++;
            if (n !== 2) begin
                miscompares++; $display("FAIL mute_restart%0d got %0d want 2", k, n);
            end
            go_silent();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int len;
        apply(6, 2, 1'b0);
        wait_level(1'b1, n);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.speaker_out !== 1'b0 || bus.tone_active !== 1'b0 || bus.cur_note !== 4'd0 || bus.cur_octave !== 2'd0) begin
            miscompares++;
            $display("FAIL rst_mid got %b/%b/%0d/%0d want 0/0/0/0", bus.speaker_out, bus.tone_active, bus.cur_note, bus.cur_octave);
        end
        reset = 1'b1;
        wait_level(1'b1, n);
        vectors++;
        if (n !== 2) begin
            miscompares++; $display("FAIL rst_restart got %0d want 2", n);
        end
        run_length(1'b1, len);
        vectors++;
        if (len !== model_half(6, 2)) begin
            miscompares++; $display("FAIL rst_half got %0d want %0d", len, model_half(6, 2));
        end
        go_silent();
    endtask

    initial begin
        reset = 1'b0;
        apply(0, 0, 1'b0);
        test_reset();
        test_a_mid();
        test_octaves();
        test_random_notes();
        test_gap();
        test_gap_change();
        test_same_key();
        test_mute();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
